demux4_2bit_stream: RTL
=======================

# demux4_2bit_stream

Registered 1-to-4 demultiplexer for 2-bit data streams. It is the distributing counterpart of the 4-to-1 2-bit selector used in the lab datapath. One producer stream carries a 2-bit destination select. Each item is steered into one of four independent output channels, and each channel has a one-entry holding register and a valid/ready handshake. Each channel also keeps a wrap-around delivery counter, so the bench and upstream logic can check per-channel throughput.

## Interface
- WIDTH, 2, data width of every stream
- CNT_W, 8, width of each per-channel delivery counter
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- in_data  input  WIDTH  payload of the producer stream
- in_sel  input  2  destination channel, 0..3
- in_valid  input  1  producer has an item on in_data/in_sel
- in_ready  output  1  block accepts the item this cycle (combinational)
- out_data  output  4*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH]
- out_valid  output  4  channel k holds an undelivered item
- out_ready  input  4  consumer k accepts the item this cycle
- count  output  4*CNT_W  channel k delivered-item count at bits [k*CNT_W +: CNT_W]

## Operation
- Per channel k, state is valid_q[k], data_q[k] and cnt_q[k]. These drive out_valid[k], out_data slice k and count slice k directly (registered outputs).
- Channel register states:
  - EMPTY (valid_q=0).
  - FULL (valid_q=1).
- in_ready = !valid_q[in_sel] | out_ready[in_sel].
  - It depends only on the selected channel; other channels never stall the input.
- Accept: acc = in_valid & in_ready. Only channel in_sel is affected.
- Deliver k: del[k] = valid_q[k] & out_ready[k].
- Next state for channel k, where a[k] = acc & (in_sel == k):
  - a[k] & !del[k]: EMPTY -> FULL; data_q <= in_data.
  - a[k] & del[k]: stays FULL (pass-through); data_q <= in_data; cnt_q increments.
  - !a[k] & del[k]: FULL -> EMPTY; cnt_q increments; data_q holds its last value.
  - neither: hold.
- Counters increment by exactly 1 per delivery and wrap modulo 2^CNT_W (255 -> 0 at CNT_W=8). No saturation, no overflow flag.
- Item ordering per channel is preserved. No item is ever dropped or duplicated.
- in_data and in_sel are ignored when in_valid=0. in_valid may drop without an accept (no stickiness required from producer).
- out_data slice k is stable while out_valid[k]=1 and out_ready[k]=0.

## Timing
- Reset values (asynchronous on rst=1, held while asserted):
  - out_valid=4'b0000
  - out_data all zero
  - count all zero
  - in_ready=1 as a consequence of all channels EMPTY
- Latency: an item accepted at edge N appears on out_valid/out_data after edge N (visible in cycle N+1). There is no combinational in->out data path.
- Throughput: one accept per cycle sustained when the target consumer holds out_ready=1. Any interleaving of channels is allowed.
- Combinational path: out_ready/in_sel -> in_ready only.
- Simultaneous events:
  - Accept to channel j and deliveries on any other channels in the same cycle all take effect at the same edge.
  - Up to 4 counters may increment in one edge.
- Reset mid-operation: held items are discarded and counters clear. The first post-reset accept behaves as from idle.
- rst deassertion is synchronous to clk at the system level. No accept occurs in a cycle where rst=1.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-stream with channels 1 and 3 FULL.
  - Required: out_valid=0000, count=0 and in_ready=1 immediately, without waiting for clk.
- Basic routing:
  - Stimulus: out_ready=1111; send data 2'b01, 2'b10, 2'b11, 2'b00 to sel 0, 1, 2, 3 on consecutive cycles.
  - Required: each out_valid[k] pulses for one cycle, one cycle after its accept, with the matching data. Final count = 1,1,1,1.
- Backpressure:
  - Stimulus: out_ready[2]=0; send 2'b11 to sel 2, then 2'b01 to sel 2.
  - Required: the first item is held and in_ready=0 while in_sel=2. A concurrent item to sel 0 is still accepted. After out_ready[2]=1 for one cycle, the second item loads the same edge (pass-through) and count[2] becomes 1.
- Pass-through stream:
  - Stimulus: out_ready[1]=1 continuously; 10 back-to-back items to sel 1.
  - Required: in_ready stays 1, out_valid[1] is high for 10 consecutive cycles, data order is preserved and count[1]=10.
- Counter wrap:
  - Stimulus: 257 deliveries on channel 3 with CNT_W=8.
  - Required: count[3] reads 255 after 255 deliveries, 0 after 256 and 1 after 257. Other counters are unchanged.
- Random soak:
  - Stimulus: random in_valid, in_sel, in_data and out_ready for 10k cycles.
  - Required: a scoreboard matches the per-channel in-order item sequence, no loss or duplication is seen, and count[k] equals the scoreboard delivery count mod 256.

Source files
------------

// File: rtl/demux4_2bit_stream_if.sv
// Producer/consumer bundle for the 1-to-4 2-bit stream demultiplexer.
// master = environment side, slave = demux side.
interface demux4_2bit_stream_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] count;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/demux4_2bit_stream.sv
// Registered 1-to-4 demultiplexer for 2-bit streams: one-entry holding
// register per channel with valid/ready handshake and a wrapping delivery counter.
//
// state | meaning
// EMPTY | channel register holds no undelivered item
// FULL  | channel register holds an item waiting for its consumer
module demux4_2bit_stream #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  demux4_2bit_stream_if.slave   bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t        state_q [4];
  ch_state_t        state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];

  logic       in_ready;
  logic       acc;
  logic [3:0] load;
  logic [3:0] del;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Only the addressed channel can stall the producer.
  always_comb begin
    in_ready = (state_q[bus.in_sel] == EMPTY) | bus.out_ready[bus.in_sel];
    acc      = bus.in_valid & in_ready;
    load     = '0;
    del      = '0;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      cnt_d[k]   = cnt_q[k];
      load[k]    = acc & (bus.in_sel == 2'(k));
      del[k]     = (state_q[k] == FULL) & bus.out_ready[k];
      if (load[k]) begin
        state_d[k] = FULL;
        data_d[k]  = bus.in_data;
      end else if (del[k]) begin
        state_d[k] = EMPTY;
      end
      if (del[k]) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = '0;
    bus.out_data  = '0;
    bus.count     = '0;
    for (int k = 0; k < 4; k++) begin
      bus.out_valid[k]                 = (state_q[k] == FULL);
      bus.out_data[k*WIDTH +: WIDTH]   = data_q[k];
      bus.count[k*CNT_W +: CNT_W]      = cnt_q[k];
    end
  end
endmodule
